// File: rtl/des_tx_pkg.sv
// Shared types and constants for the DES transmit serializer.
// Holds the serializer FSM state encoding and the block geometry.
// Imported by des_tx_serializer and tx_byte_counter.
package des_tx_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      ACK      = 2'd2,
      WAIT_LOW = 2'd3
   } tx_state_e;

   localparam int BYTES_PER_BLOCK = 8;
   localparam int CNT_W           = $clog2(BYTES_PER_BLOCK);

endpackage

// File: rtl/tx_byte_counter.sv
// Byte counter for one 64-bit block: counts bytes handed to the transmit FIFO.
// Latency: count updates on the clock edge after count_enable; rollover is combinational from the count.
// Ports: clk, n_rst (async active-low), clear, count_enable in; rollover (count == last byte) out.
module tx_byte_counter
   import des_tx_pkg::*;
(
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   input  logic count_enable,
   output logic rollover
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (count_enable) begin
         // Natural wrap from 7 back to 0 leaves the counter ready for the next block.
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign rollover = (cnt_q == CNT_W'(BYTES_PER_BLOCK - 1));

endmodule

// File: rtl/des_tx_serializer.sv
// Splits a 64-bit DES result block into 8 byte writes toward the transmit FIFO, then acks the core.
// Latency: transmit_signal seen at edge N -> bytes in cycles N+1..N+8, packet_ack in N+9 (no stalls).
// Backpressure: fifo_full holds the shift register and byte count; the block is never dropped.
module des_tx_serializer
   import des_tx_pkg::*;
#(
   parameter int MSB_FIRST = 1
)
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        transmit_signal,
   input  logic [63:0] trans_data,
   input  logic        fifo_full,
   output logic        fifo_write,
   output logic [7:0]  fifo_wdata,
   output logic        packet_ack,
   output logic        busy
);

   tx_state_e   state_q;
   tx_state_e   state_d;
   logic [63:0] shreg_q;
   logic [63:0] shreg_d;
   logic [63:0] shreg_next;
   logic        cnt_clear;
   logic        cnt_rollover;

   // The outgoing byte always sits at the end of the register nearest the output,
   // so shifting by one byte exposes the next one.
   assign shreg_next = (MSB_FIRST != 0) ? {shreg_q[55:0], 8'h00}
                                        : {8'h00, shreg_q[63:8]};
   assign fifo_wdata = (MSB_FIRST != 0) ? shreg_q[63:56] : shreg_q[7:0];
   assign busy       = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_clear  = 1'b0;
      fifo_write = 1'b0;
      packet_ack = 1'b0;
      case (state_q)
         IDLE: begin
            if (transmit_signal) begin
               shreg_d   = trans_data;
               cnt_clear = 1'b1;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (!fifo_full) begin
               fifo_write = 1'b1;
               shreg_d    = shreg_next;
               if (cnt_rollover) begin
                  state_d = ACK;
               end
            end
         end
         ACK: begin
            packet_ack = 1'b1;
            state_d    = WAIT_LOW;
         end
         WAIT_LOW: begin
            // The core keeps transmit_signal high until it sees the ack; wait for it
            // to drop so the same block is not serialized twice.
            if (!transmit_signal) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
      end
   end

   tx_byte_counter u_byte_counter (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (cnt_clear),
      .count_enable (fifo_write),
      .rollover     (cnt_rollover)
   );

endmodule

// File: tb/tb_des_tx_serializer.sv
// Directed bench for des_tx_serializer: both byte orders, stalls, data hold, reset, re-arm.
// Outputs are recorded on the falling edge; inputs change 1 time unit after the rising edge.
// Every comparison is an immediate assertion that counts failures and reports observed/expected.
module tb_des_tx_serializer;

   logic        clk;
   logic        n_rst;
   logic        transmit_signal;
   logic [63:0] trans_data;
   logic        fifo_full;
   logic        fifo_write;
   logic [7:0]  fifo_wdata;
   logic        packet_ack;
   logic        busy;
   logic        l_fifo_write;
   logic [7:0]  l_fifo_wdata;
   logic        l_packet_ack;
   logic        l_busy;

   int          checks;
   int          failures;
   int          cyc;
   int          n0;

   logic [7:0]  wq[$];
   int          wc[$];
   int          aq[$];
   logic [7:0]  lq[$];
   int          la;

   des_tx_serializer #(.MSB_FIRST(1)) dut (
      .clk             (clk),
      .n_rst           (n_rst),
      .transmit_signal (transmit_signal),
      .trans_data      (trans_data),
      .fifo_full       (fifo_full),
      .fifo_write      (fifo_write),
      .fifo_wdata      (fifo_wdata),
      .packet_ack      (packet_ack),
      .busy            (busy)
   );

   des_tx_serializer #(.MSB_FIRST(0)) dut_lsb (
      .clk             (clk),
      .n_rst           (n_rst),
      .transmit_signal (transmit_signal),
      .trans_data      (trans_data),
      .fifo_full       (fifo_full),
      .fifo_write      (l_fifo_write),
      .fifo_wdata      (l_fifo_wdata),
      .packet_ack      (l_packet_ack),
      .busy            (l_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Cycle k is the interval ending at rising edge k; at the falling edge inside it cyc == k-1.
   always @(negedge clk) begin
      if (fifo_write) begin
         wq.push_back(fifo_wdata);
         wc.push_back(cyc + 1);
      end
      if (packet_ack) aq.push_back(cyc + 1);
      if (l_fifo_write) lq.push_back(l_fifo_wdata);
      if (l_packet_ack) la = la + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      wq.delete();
      wc.delete();
      aq.delete();
      lq.delete();
      la = 0;
   endtask

   // Raise transmit_signal with a block; it is sampled at the next edge, recorded as n0.
   task automatic load(input logic [63:0] d);
      trans_data      = d;
      transmit_signal = 1'b1;
      n0              = cyc + 1;
   endtask

   function automatic logic [7:0] bmsb(input logic [63:0] d, input int i);
      logic [63:0] t;
      t = d >> (8 * (7 - i));
      return t[7:0];
   endfunction

   function automatic logic [7:0] blsb(input logic [63:0] d, input int i);
      logic [63:0] t;
      t = d >> (8 * i);
      return t[7:0];
   endfunction

   localparam logic [63:0] BLK_A = 64'h0123456789ABCDEF;
   localparam logic [63:0] BLK_B = 64'hDEADBEEFCAFEF00D;
   localparam logic [63:0] BLK_C = 64'h1122334455667788;

   initial begin
      checks          = 0;
      failures        = 0;
      la              = 0;
      n0              = 0;
      n_rst           = 1'b0;
      transmit_signal = 1'b0;
      trans_data      = 64'h0;
      fifo_full       = 1'b0;

      // Reset state
      #3;
      chk("rst_fifo_write", fifo_write, 1'b0);
      chk("rst_fifo_wdata", fifo_wdata, 8'h00);
      chk("rst_packet_ack", packet_ack, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_lsb_wdata", l_fifo_wdata, 8'h00);
      tick(2);
      n_rst = 1'b1;
      tick(2);
      chk("idle_busy", busy, 1'b0);

      // Block A, no stalls, transmit held high; both byte orders
      clear_logs();
      load(BLK_A);
      tick(3);
      chk("t1_busy_send", busy, 1'b1);
      chk("t1_write_send", fifo_write, 1'b1);
      tick(9);
      chk("t1_count", wq.size(), 8);
      for (int i = 0; i < 8 && i < wq.size(); i++) begin
         chk("t1_byte", wq[i], bmsb(BLK_A, i));
         chk("t1_cycle", wc[i], n0 + 1 + i);
      end
      chk("t1_ack_count", aq.size(), 1);
      if (aq.size() > 0) chk("t1_ack_cycle", aq[0], n0 + 9);
      chk("t1_lsb_count", lq.size(), 8);
      for (int i = 0; i < 8 && i < lq.size(); i++) begin
         chk("t1_lsb_byte", lq[i], blsb(BLK_A, i));
      end
      chk("t1_lsb_ack", la, 1);
      chk("t1_wait_busy", busy, 1'b1);
      tick(5);
      chk("t1_single_block", wq.size(), 8);
      transmit_signal = 1'b0;
      tick(2);
      chk("t1_idle_busy", busy, 1'b0);

      // Stall 3 cycles after the 3rd byte; transmit dropped mid-block
      clear_logs();
      load(BLK_A);
      tick(1);
      transmit_signal = 1'b0;
      tick(3);
      fifo_full = 1'b1;
      #1;
      chk("t2_stall_write", fifo_write, 1'b0);
      tick(3);
      fifo_full = 1'b0;
      tick(8);
      chk("t2_count", wq.size(), 8);
      for (int i = 0; i < 8 && i < wq.size(); i++) begin
         chk("t2_byte", wq[i], bmsb(BLK_A, i));
         chk("t2_cycle", wc[i], (i < 3) ? n0 + 1 + i : n0 + 4 + i);
      end
      chk("t2_ack_count", aq.size(), 1);
      if (aq.size() > 0) chk("t2_ack_cycle", aq[0], n0 + 12);
      chk("t2_idle_busy", busy, 1'b0);

      // trans_data overwritten one cycle after the load
      clear_logs();
      load(BLK_A);
      tick(1);
      trans_data = 64'hFFFFFFFFFFFFFFFF;
      tick(11);
      transmit_signal = 1'b0;
      chk("t3_count", wq.size(), 8);
      for (int i = 0; i < 8 && i < wq.size(); i++) begin
         chk("t3_byte", wq[i], bmsb(BLK_A, i));
      end
      chk("t3_ack_count", aq.size(), 1);
      tick(2);

      // Reset pulse after the 4th byte
      clear_logs();
      load(BLK_A);
      tick(5);
      chk("t4_pre_write", fifo_write, 1'b1);
      n_rst           = 1'b0;
      transmit_signal = 1'b0;
      #1;
      chk("t4_rst_write", fifo_write, 1'b0);
      chk("t4_rst_wdata", fifo_wdata, 8'h00);
      chk("t4_rst_ack", packet_ack, 1'b0);
      chk("t4_rst_busy", busy, 1'b0);
      tick(3);
      n_rst = 1'b1;
      tick(4);
      chk("t4_writes_kept", wq.size(), 4);
      chk("t4_no_ack", aq.size(), 0);
      chk("t4_idle_busy", busy, 1'b0);
      clear_logs();
      load(BLK_C);
      tick(12);
      transmit_signal = 1'b0;
      chk("t4_new_count", wq.size(), 8);
      for (int i = 0; i < 8 && i < wq.size(); i++) begin
         chk("t4_new_byte", wq[i], bmsb(BLK_C, i));
      end
      chk("t4_new_ack", aq.size(), 1);
      tick(2);

      // Held high past the ack, then re-armed with a second block
      clear_logs();
      load(BLK_A);
      tick(10);
      tick(20);
      chk("t5_no_resend", wq.size(), 8);
      transmit_signal = 1'b0;
      tick(2);
      load(BLK_B);
      tick(12);
      transmit_signal = 1'b0;
      tick(2);
      chk("t5_total_writes", wq.size(), 16);
      for (int i = 0; i < 8 && (8 + i) < wq.size(); i++) begin
         chk("t5_byte", wq[8 + i], bmsb(BLK_B, i));
      end
      chk("t5_ack_count", aq.size(), 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
